// File: rtl/serial_compare_flag_gen_if.sv
// Request/result bundle for the serial subtract-and-flag generator.
// master drives requests and the result acknowledge; slave is the generator.
interface serial_compare_flag_gen_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             a31;
  logic             b31;
  logic             carry;
  logic             zero;
  logic             diff;
  logic [2:0]       op_out;

  modport master (
    output start, a, b, op, out_ready,
    input  start_ready, out_valid, result, a31, b31, carry, zero, diff, op_out
  );

  modport slave (
    input  start, a, b, op, out_ready,
    output start_ready, out_valid, result, a31, b31, carry, zero, diff, op_out
  );
endinterface

// File: rtl/serial_compare_flag_gen.sv
// Digit-serial a - b (as a + ~b + 1), LSB digit first, producing the
// operand signs, carry, zero and difference-sign flags for the compare unit.
module serial_compare_flag_gen #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  serial_compare_flag_gen_if.slave s
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a31_q, a31_d, b31_q, b31_d;
  logic             carry_q, carry_d, zero_q, zero_d, diff_q, diff_d;
  logic [2:0]       op_out_q, op_out_d;

  logic [WIDTH-1:0] a_q, a_d, nb_q, nb_d;
  logic [2:0]       op_q, op_d;
  logic             cry_q, cry_d, zacc_q, zacc_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   sum;

  // Digit select and the DIGIT-bit adder slice
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = nb_q[i*DIGIT +: DIGIT];
      end
    end
    sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cry_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    res_d    = res_q;
    a31_d    = a31_q;
    b31_d    = b31_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    diff_d   = diff_q;
    op_out_d = op_out_q;
    a_d      = a_q;
    nb_d     = nb_q;
    op_d     = op_q;
    cry_d    = cry_q;
    zacc_d   = zacc_q;
    case (state_q)
      IDLE: begin
        if (s.start) begin
          state_d = RUN;
          a_d     = s.a;
          nb_d    = ~s.b;
          op_d    = s.op;
          cry_d   = 1'b1;
          cnt_d   = '0;
          zacc_d  = 1'b1;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) res_d[i*DIGIT +: DIGIT] = sum[DIGIT-1:0];
        end
        cry_d  = sum[DIGIT];
        zacc_d = zacc_q & (sum[DIGIT-1:0] == '0);
        cnt_d  = cnt_q + 1'b1;
        // Last digit: publish flags straight from the final slice
        if (cnt_q == CW'(N - 1)) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          carry_d  = sum[DIGIT];
          zero_d   = zacc_d;
          diff_d   = sum[DIGIT-1];
          a31_d    = a_q[WIDTH-1];
          b31_d    = ~nb_q[WIDTH-1];
          op_out_d = op_q;
        end
      end
      DONE: begin
        if (s.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      res_q    <= '0;
      a31_q    <= 1'b0;
      b31_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      diff_q   <= 1'b0;
      op_out_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
      a31_q    <= a31_d;
      b31_q    <= b31_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      diff_q   <= diff_d;
      op_out_q <= op_out_d;
    end
  end

  // Working operands are always reloaded on acceptance, so they need no reset
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    nb_q   <= nb_d;
    op_q   <= op_d;
    cry_q  <= cry_d;
    zacc_q <= zacc_d;
  end

  assign s.start_ready = (state_q == IDLE);
  assign s.out_valid   = valid_q;
  assign s.result      = res_q;
  assign s.a31         = a31_q;
  assign s.b31         = b31_q;
  assign s.carry       = carry_q;
  assign s.zero        = zero_q;
  assign s.diff        = diff_q;
  assign s.op_out      = op_out_q;
endmodule

// File: tb/tb_serial_compare_flag_gen.sv
// Directed bench for serial_compare_flag_gen: DIGIT=4 main instance plus a
// DIGIT=1 instance for the 32-cycle latency case.
module tb_serial_compare_flag_gen;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   lat;

  serial_compare_flag_gen_if #(.WIDTH(32)) m_if ();
  serial_compare_flag_gen_if #(.WIDTH(32)) u_if ();

  serial_compare_flag_gen #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .s(m_if.slave)
  );
  serial_compare_flag_gen #(.WIDTH(32), .DIGIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .s(u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string t, input logic [31:0] r, input logic c,
                            input logic z, input logic d, input logic sa,
                            input logic sb, input logic [2:0] o);
    chk({t, ".result"}, m_if.result, r);
    chk({t, ".carry"},  32'(m_if.carry), 32'(c));
    chk({t, ".zero"},   32'(m_if.zero), 32'(z));
    chk({t, ".diff"},   32'(m_if.diff), 32'(d));
    chk({t, ".a31"},    32'(m_if.a31), 32'(sa));
    chk({t, ".b31"},    32'(m_if.b31), 32'(sb));
    chk({t, ".op_out"}, 32'(m_if.op_out), 32'(o));
  endtask

  task automatic launch(input string t, input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] opv);
    @(negedge clk);
    chk({t, ".ready_before"}, 32'(m_if.start_ready), 32'd1);
    m_if.start = 1'b1;
    m_if.a     = av;
    m_if.b     = bv;
    m_if.op    = opv;
    @(negedge clk);
    m_if.start = 1'b0;
    m_if.a     = ~av;
    m_if.b     = ~bv;
    m_if.op    = ~opv;
    chk({t, ".ready_run"}, 32'(m_if.start_ready), 32'd0);
  endtask

  task automatic wait_valid(input int budget, output int l);
    l = 0;
    while (m_if.out_valid !== 1'b1 && l < budget) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset_n = 1'b1;
    m_if.start = 1'b0; m_if.a = '0; m_if.b = '0; m_if.op = '0; m_if.out_ready = 1'b0;
    u_if.start = 1'b0; u_if.a = '0; u_if.b = '0; u_if.op = '0; u_if.out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst.valid", 32'(m_if.out_valid), 32'd0);
    chk("rst.ready", 32'(m_if.start_ready), 32'd1);
    expect_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    m_if.out_ready = 1'b1;
    launch("eq", 32'd5, 32'd5, 3'b100);
    wait_valid(20, lat);
    chk("eq.latency", 32'(lat), 32'd8);
    expect_out("eq", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    chk("eq.ready_done", 32'(m_if.start_ready), 32'd0);
    @(negedge clk);
    chk("eq.one_cycle", 32'(m_if.out_valid), 32'd0);
    chk("eq.ready_idle", 32'(m_if.start_ready), 32'd1);

    launch("min", 32'h8000_0000, 32'h0000_0001, 3'b001);
    wait_valid(20, lat);
    chk("min.latency", 32'(lat), 32'd8);
    expect_out("min", 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
    @(negedge clk);

    launch("lt", 32'd3, 32'd7, 3'b010);
    wait_valid(20, lat);
    expect_out("lt", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
    @(negedge clk);

    // Back-pressure with stray 9/9 requests during RUN and DONE
    m_if.out_ready = 1'b0;
    launch("hold", 32'd3, 32'd7, 3'b010);
    m_if.a = 32'd9; m_if.b = 32'd9; m_if.op = 3'b111;
    for (int i = 0; i < 3; i++) begin
      m_if.start = 1'b1;
      @(negedge clk);
      chk("hold.ready_run", 32'(m_if.start_ready), 32'd0);
    end
    m_if.start = 1'b0;
    wait_valid(20, lat);
    chk("hold.latency", 32'(lat + 3), 32'd8);
    for (int i = 0; i < 3; i++) begin
      m_if.start = 1'b1;
      @(negedge clk);
      chk("hold.valid", 32'(m_if.out_valid), 32'd1);
      chk("hold.ready_done", 32'(m_if.start_ready), 32'd0);
      expect_out("hold", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010);
    end
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    chk("hold.release", 32'(m_if.out_valid), 32'd0);
    chk("hold.not_accepted", 32'(m_if.start_ready), 32'd1);
    @(negedge clk);
    chk("hold.still_idle", 32'(m_if.start_ready), 32'd1);
    chk("hold.result_kept", m_if.result, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of RUN
    launch("abort", 32'hFFFF_FFFF, 32'h0, 3'b011);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort.valid", 32'(m_if.out_valid), 32'd0);
    chk("abort.ready", 32'(m_if.start_ready), 32'd1);
    expect_out("abort", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort.idle_valid", 32'(m_if.out_valid), 32'd0);
    launch("post", 32'h10, 32'h20, 3'b000);
    wait_valid(20, lat);
    chk("post.latency", 32'(lat), 32'd8);
    expect_out("post", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);

    // Bit-serial instance
    u_if.out_ready = 1'b1;
    @(negedge clk);
    chk("d1.ready_before", 32'(u_if.start_ready), 32'd1);
    u_if.start = 1'b1; u_if.a = 32'h0; u_if.b = 32'h0; u_if.op = 3'b101;
    @(negedge clk);
    u_if.start = 1'b0;
    lat = 0;
    while (u_if.out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("d1.latency", 32'(lat), 32'd32);
    chk("d1.zero", 32'(u_if.zero), 32'd1);
    chk("d1.carry", 32'(u_if.carry), 32'd1);
    chk("d1.result", u_if.result, 32'h0);
    chk("d1.op_out", 32'(u_if.op_out), 32'd5);
    @(negedge clk);
    chk("d1.one_cycle", 32'(u_if.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_compare_flag_gen.md
# serial_compare_flag_gen

Multi-cycle subtract-and-flag generator that produces the operand sign bits, carry, zero and difference-sign flags, plus the latched opcode, consumed by the comparison unit in the Part 1 ALU datapath. It computes a − b as a + ~b + 1, DIGIT bits per cycle, LSB first, trading a full-width subtractor for a small adder slice. It sits between the operand registers and the comparison unit. It uses a start/ready request side and a valid/ready result side.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when start_ready=1
- start_ready  out  1  high in IDLE
- a  in  WIDTH  minuend, sampled on the accepting edge
- b  in  WIDTH  subtrahend, sampled on the accepting edge
- op  in  3  comparison opcode, sampled on the accepting edge
- out_valid  out  1  flags/result valid; held until out_ready
- out_ready  in  1  consumer acknowledge
- result  out  WIDTH  a − b mod 2^WIDTH
- a31  out  1  a[WIDTH-1] of the accepted operand
- b31  out  1  b[WIDTH-1] of the accepted operand
- carry  out  1  carry-out of a + ~b + 1; 1 ⇔ a ≥ b unsigned
- zero  out  1  result == 0
- diff  out  1  result[WIDTH-1]
- op_out  out  3  op of the accepted request

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start=1 (start_ready=1 in IDLE):
  - latch a, ~b and op;
  - carry register := 1 (the +1);
  - digit counter := 0;
  - zero accumulator := 1.
- RUN, each cycle:
  - add digit[cnt] of a and of ~b plus the carry register;
  - write the DIGIT-bit sum into result[cnt*DIGIT +: DIGIT];
  - carry register := slice carry-out;
  - zero accumulator &= (sum digit == 0);
  - cnt++.
- RUN → DONE after the digit with cnt = WIDTH/DIGIT − 1.
- On entry to DONE:
  - carry, zero, diff, a31, b31 and op_out update from the internal state;
  - out_valid := 1.
- DONE: all outputs hold stable while out_ready=0. On out_ready=1: out_valid := 0 and state → IDLE. The flags keep their last values until the next DONE entry.
- start is ignored in RUN and DONE, including start together with out_ready in DONE. The earliest next acceptance is the cycle after DONE exits.
- Arithmetic is modulo 2^WIDTH. There is no overflow flag; signed ordering is resolved downstream from a31/b31/diff.
- Reset (asynchronous, any state including mid-RUN):
  - state := IDLE;
  - out_valid := 0 and start_ready := 1;
  - result, a31, b31, carry, zero, diff := 0 and op_out := 000;
  - the partial computation is discarded.

## Timing
- Let N = WIDTH/DIGIT (8 by default).
- Accepting edge k. The RUN digit operations occur at edges k+1 … k+N.
- out_valid and all flags are valid after edge k+N. The latency from start to valid is N cycles.
- result digits update progressively during RUN. The consumer uses result and the flags only while out_valid=1.
- With out_ready=1 already high, out_valid stays high for exactly one cycle. IDLE follows, so the minimum initiation interval is N+2 cycles.
- start_ready is combinational from state only and has no dependency on start.
- Operands are not required to stay stable after the accepting edge.

## Test plan
- Reset then a=5, b=5, op=100, out_ready=1:
  - after 8 cycles, one-cycle out_valid;
  - result=0, zero=1, carry=1, diff=0, a31=0, b31=0, op_out=100.
- a=0x80000000, b=0x00000001, op=001:
  - result=0x7FFFFFFF, diff=0, carry=1, zero=0;
  - a31=1, b31=0, op_out=001.
- a=3, b=7, op=010:
  - result=0xFFFFFFFC, diff=1, carry=0, zero=0, a31=0, b31=0.
- a=3, b=7 with out_ready=0 for 3 cycles after valid, and start pulsed with a=9, b=9 during RUN and during DONE:
  - out_valid held and all outputs unchanged for 3 cycles;
  - the 9/9 requests are ignored;
  - start_ready=0 throughout.
- Start a=0xFFFFFFFF, b=0, then drop reset_n at RUN cycle 4:
  - all outputs 0 and start_ready=1 immediately, without waiting for a clock edge;
  - after release, a=0x10, b=0x20 yields result=0xFFFFFFF0, carry=0, diff=1.
- DIGIT=1, a=0, b=0:
  - valid exactly 32 cycles after the accepting edge;
  - zero=1, carry=1.
